// File: rtl/prog_memory.sv
// Program/data register memory with a fetch port, a read/write data port and a
// valid/ready serial download engine. Define PROG_MEM_CLEAR_EN to zero-fill the array after reset.
module prog_memory #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    output logic                  load_ready_o,
    output logic                  load_done_o,
    output logic                  busy_o,
    input  logic                  fetch_en_i,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    output logic [DATA_WIDTH-1:0] fetch_data_o,
    input  logic                  data_write_en_i,
    input  logic                  data_read_en_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef PROG_MEM_CLEAR_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR} state_t;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    typedef enum logic [0:0] {S_IDLE, S_LOAD} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   lptr_q, lptr_d;
    logic                    load_done_q, load_done_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return 32'(addr) < DEPTH;
    endfunction

    // Next state, load pointer and the single array write port.
    always_comb begin
        state_d     = state_q;
        lptr_d      = lptr_q;
        load_done_d = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = data_addr_i;
        wr_data     = data_i;

        case (state_q)
            S_IDLE: begin
                // The CPU write still lands in the cycle a download is started.
                if (data_write_en_i && in_range(data_addr_i)) begin
                    wr_en = 1'b1;
                end
                if (load_start_i) begin
                    state_d = S_LOAD;
                    lptr_d  = '0;
                end
            end

            S_LOAD: begin
                if (load_start_i) begin
                    lptr_d = '0;
                end else if (load_valid_i) begin
                    wr_en   = 1'b1;
                    wr_addr = lptr_q;
                    wr_data = load_data_i;
                    if (lptr_q == LAST_ADDR) begin
                        state_d     = S_IDLE;
                        lptr_d      = '0;
                        load_done_d = 1'b1;
                    end else begin
                        lptr_d = lptr_q + 1'b1;
                    end
                end
            end

`ifdef PROG_MEM_CLEAR_EN
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = lptr_q;
                wr_data = '0;
                if (lptr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    lptr_d  = '0;
                end else begin
                    lptr_d = lptr_q + 1'b1;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
                lptr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= RESET_STATE;
            lptr_q      <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lptr_q      <= lptr_d;
            load_done_q <= load_done_d;
        end
    end

    // Array is not reset; with the clear option the CLEAR walk zero-fills it.
    always_ff @(posedge clk_i) begin
        if (wr_en && !reset_i) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign load_ready_o = (state_q == S_LOAD);
    assign busy_o       = (state_q != S_IDLE);
    assign load_done_o  = load_done_q;

    always_comb begin
        fetch_data_o = '0;
        data_o       = '0;
        if (state_q == S_IDLE) begin
            if (fetch_en_i && in_range(fetch_addr_i)) begin
                fetch_data_o = mem_q[fetch_addr_i];
            end
            if (data_read_en_i && in_range(data_addr_i)) begin
                data_o = mem_q[data_addr_i];
            end
        end
    end

endmodule

// File: doc/prog_memory.md
# prog_memory

Parametrised program/data register memory for the 4-bit CPU, generalising the fixed 16x4 register memory. It has two read ports: an instruction-fetch port and a data port, and the data port can also write. A serial load engine lets the program image be streamed in over a valid/ready handshake, so the program no longer has to be hard-wired at reset. It sits between the CPU core (fetch and LD/ST accesses) and the top-level I/O pins used for program download.

## Interface
- DEPTH, 16: number of words; must be ≤ 2^ADDR_WIDTH.
- DATA_WIDTH, 4: word width in bits.
- ADDR_WIDTH, 4: address width in bits.
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_i  in  1  reset: one clock; synchronous, active-high.
- load_start_i  in  1  starts or restarts a program download.
- load_valid_i  in  1  load_data_i holds a valid beat.
- load_data_i  in  DATA_WIDTH  download word.
- load_ready_o  out  1  engine accepts a beat this cycle.
- load_done_o  out  1  one-cycle pulse after the last beat is written.
- busy_o  out  1  engine in LOAD or CLEAR; CPU ports inactive.
- fetch_en_i  in  1  fetch port read enable.
- fetch_addr_i  in  ADDR_WIDTH  fetch address.
- fetch_data_o  out  DATA_WIDTH  fetch read data, combinational.
- data_write_en_i  in  1  data port write enable.
- data_read_en_i  in  1  data port read enable.
- data_addr_i  in  ADDR_WIDTH  data port address.
- data_i  in  DATA_WIDTH  data port write data.
- data_o  out  DATA_WIDTH  data port read data, combinational.

## Operation
- **Storage:** array mem[0..DEPTH-1] of DATA_WIDTH bits. There is a single write per cycle, from either the load engine or the data port, never both.
- **States:**
  - IDLE: CPU ports active.
  - LOAD: download in progress.
  - CLEAR: zero-fill; exists only with the macro.
  - A load pointer lptr of ADDR_WIDTH bits accompanies the state.
- **IDLE:**
  - data_write_en_i=1 writes data_i to mem[data_addr_i].
  - fetch_data_o = fetch_en_i ? mem[fetch_addr_i] : 0.
  - data_o = data_read_en_i ? mem[data_addr_i] : 0.
  - load_start_i=1 sets lptr=0 and moves to LOAD. The data-port write in that same cycle still executes.
- **LOAD:**
  - load_ready_o=1 and busy_o=1.
  - fetch_data_o and data_o are forced to 0; data-port writes are ignored.
  - Each cycle with load_valid_i=1 writes load_data_i to mem[lptr] and increments lptr.
  - The beat at lptr=DEPTH-1 writes, then returns to IDLE with lptr=0, and load_done_o=1 for the next cycle.
- **Restart in LOAD:** load_start_i=1 sets lptr=0 and drops any beat presented that cycle (not written, not counted).
- **Out-of-range addresses:** an address ≥ DEPTH makes a write a no-op and a read return 0. lptr never exceeds DEPTH-1.
- **Same-cycle read and write to one address:** data and fetch reads return the old value; the new value is visible after the edge.
- **Reset mid-LOAD:** the download is aborted. Without the macro, words already loaded are retained and the state goes to IDLE.

## Timing
- Reset values of outputs: load_ready_o=0, load_done_o=0, busy_o=0 (1 with the macro), fetch_data_o=0, data_o=0.
  - fetch_data_o and data_o are 0 because the enables are expected low during reset.
- Array contents are not reset without the macro; unwritten words read X in simulation.
- State, lptr and load_done_o are registered. load_ready_o and busy_o decode from the registered state only, with no combinational path from load_valid_i.
- Reads have zero latency (combinational from the array). Writes are visible the cycle after the write edge.
- A full download takes DEPTH accepting cycles. Stalls from load_valid_i=0 are allowed at any point.
- busy_o falls in the same cycle load_done_o rises.

## Configuration
- Macro: PROG_MEM_CLEAR_EN.
- **Defined:**
  - reset_i forces CLEAR with lptr=0.
  - Each cycle in CLEAR writes 0 to mem[lptr] and increments lptr. After DEPTH cycles (on wrap from DEPTH-1) the state goes to IDLE.
  - busy_o=1 and load_ready_o=0 during CLEAR. load_start_i and CPU writes are ignored, and reads return 0.
  - Reset mid-LOAD restarts the CLEAR, erasing any partial image.
  - No load_done_o pulse is generated after CLEAR.
- **Undefined:** there is no CLEAR state and reset goes directly to IDLE.

## Test plan
- **Full download:** pulse load_start_i, then stream 16 beats 0xF,0xE,…,0x0 with no stalls. Required: load_done_o pulses exactly once, one cycle after the 16th beat. Fetch of addresses 0..15 then returns 0xF..0x0.
- **Stalled download:** insert load_valid_i=0 gaps after beats 3 and 9. Required: identical final contents; load_ready_o stays 1 throughout; lptr does not advance during gaps.
- **Restart mid-download:** after 5 beats, assert load_start_i together with a valid beat 0xA, then stream 16 beats of 0x3. Required: 0xA is never written, all words read 0x3, and only one load_done_o pulse occurs.
- **Data port in IDLE:**
  - Write 0x9 to address 4 while reading address 4. Required: data_o shows the old value that cycle and 0x9 the next cycle.
  - data_read_en_i=0 gives data_o=0.
- **Port gating:** during LOAD, assert fetch/data reads and a data write of 0x7 to address 2. Required: fetch_data_o=data_o=0 and mem[2] holds its downloaded value afterwards.
- **PROG_MEM_CLEAR_EN:** load all words with 0x5, then reset for 1 cycle. Required: busy_o=1 for exactly 16 cycles, then every address reads 0x0. A reset at beat 7 of a later download also ends with all words 0x0.
